// File: rtl/bus_arbiter.sv
// Single-port Wishbone-style bus arbiter shared by instruction fetch and the MEM stage.
// Sequences one transaction at a time, holds returned data for frozen stages, drains on flush.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        stallreq_if,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        stallreq_mem,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, IFETCH, DMEM, DRAIN} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [7:0]  tcount;
  logic [31:0] ibuf, dbuf;
  logic        ibuf_valid, dbuf_valid;

  logic        done, if_done, mem_done;
  logic [31:0] bus_data_ret;
  logic        unused_stall_bits;

  assign unused_stall_bits = ^{stall[5], stall[3:2], stall[0]};

  // A transaction ends on ack or on the timeout cycle (bus_err), whichever comes first.
  assign done     = (state != IDLE) && (bus_ack || bus_err);
  assign if_done  = (state == IFETCH) && done;
  assign mem_done = (state == DMEM) && done;

  assign bus_data_ret = bus_err ? 32'h0 : bus_rdata;
  assign if_rdata     = ibuf_valid ? ibuf : bus_data_ret;
  assign mem_rdata    = dbuf_valid ? dbuf : bus_data_ret;

  assign stallreq_if  = if_req  && !ibuf_valid && !if_done;
  assign stallreq_mem = mem_req && !dbuf_valid && !mem_done;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the data buffers are reset too; their valid flags gate them, but a known value keeps X out of the rdata muxes.
    if (!rst) begin
      state      <= IDLE;
      tcount     <= '0;
      ibuf       <= '0;
      dbuf       <= '0;
      ibuf_valid <= 1'b0;
      dbuf_valid <= 1'b0;
      bus_cyc    <= 1'b0;
      bus_stb    <= 1'b0;
      bus_we     <= 1'b0;
      bus_sel    <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= 1'b0;

      // Hold buffers: capture when the consumer is frozen, release on its first free edge.
      if (flush) begin
        ibuf_valid <= 1'b0;
        dbuf_valid <= 1'b0;
      end else begin
        if (ibuf_valid && !stall[1]) begin
          ibuf_valid <= 1'b0;
        end else if (if_done && stall[1]) begin
          ibuf       <= bus_data_ret;
          ibuf_valid <= 1'b1;
        end
        if (dbuf_valid && !stall[4]) begin
          dbuf_valid <= 1'b0;
        end else if (mem_done && stall[4]) begin
          dbuf       <= bus_data_ret;
          dbuf_valid <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (!flush) begin
            if (mem_req && !dbuf_valid) begin
              bus_cyc   <= 1'b1;
              bus_stb   <= 1'b1;
              bus_we    <= mem_we;
              bus_sel   <= mem_sel;
              bus_addr  <= mem_addr;
              bus_wdata <= mem_wdata;
              tcount    <= '0;
              state     <= DMEM;
            end else if (if_req && !ibuf_valid) begin
              bus_cyc   <= 1'b1;
              bus_stb   <= 1'b1;
              bus_we    <= 1'b0;
              bus_sel   <= 4'hF;
              bus_addr  <= if_addr;
              bus_wdata <= '0;
              tcount    <= '0;
              state     <= IFETCH;
            end
          end
        end
        default: begin
          if (done) begin
            bus_cyc   <= 1'b0;
            bus_stb   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            state     <= IDLE;
          end else begin
            // A flushed transaction stays on the bus until the slave answers or times out.
            if (flush) state <= DRAIN;
            if (tcount == TO_LAST) bus_err <= 1'b1;
            tcount <= tcount + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: fetch, contention, hold buffer, flush drain, timeout, async reset.
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        stallreq_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stallreq_mem;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .stallreq_if  (stallreq_if),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .stallreq_mem (stallreq_mem),
    .bus_cyc      (bus_cyc),
    .bus_stb      (bus_stb),
    .bus_we       (bus_we),
    .bus_sel      (bus_sel),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc", {31'b0, bus_cyc}, 32'd0);
    check("rst_stb", {31'b0, bus_stb}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_err", {31'b0, bus_err}, 32'd0);
    #3 rst = 1'b1;

    // Single fetch, ack in the first strobe cycle
    step();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    check("f1_stallreq_req", {31'b0, stallreq_if}, 32'd1);
    check("f1_stb_idle", {31'b0, bus_stb}, 32'd0);
    step();
    bus_ack = 1'b1; bus_rdata = 32'h3C010001;
    #1;
    check("f1_stb", {31'b0, bus_stb}, 32'd1);
    check("f1_addr", bus_addr, 32'h100);
    check("f1_sel", {28'b0, bus_sel}, 32'hF);
    check("f1_we", {31'b0, bus_we}, 32'd0);
    check("f1_rdata", if_rdata, 32'h3C010001);
    check("f1_stallreq_ack", {31'b0, stallreq_if}, 32'd0);
    step();
    bus_ack = 1'b0; if_req = 1'b0;
    #1;
    check("f1_cyc_after", {31'b0, bus_cyc}, 32'd0);

    // Contention: MEM load wins, fetch follows
    step();
    if_req = 1'b1; if_addr = 32'h104;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h2000;
    #1;
    check("c_stallreq_mem", {31'b0, stallreq_mem}, 32'd1);
    check("c_stallreq_if", {31'b0, stallreq_if}, 32'd1);
    step();
    #1;
    check("c_mem_addr", bus_addr, 32'h2000);
    check("c_mem_stb", {31'b0, bus_stb}, 32'd1);
    step();
    bus_ack = 1'b1; bus_rdata = 32'h11112222;
    #1;
    check("c_mem_rdata", mem_rdata, 32'h11112222);
    check("c_mem_stallreq", {31'b0, stallreq_mem}, 32'd0);
    check("c_if_still_stalled", {31'b0, stallreq_if}, 32'd1);
    step();
    bus_ack = 1'b0; mem_req = 1'b0;
    #1;
    check("c_gap_stb", {31'b0, bus_stb}, 32'd0);
    check("c_gap_stallreq_if", {31'b0, stallreq_if}, 32'd1);
    step();
    bus_ack = 1'b1; bus_rdata = 32'h22223333;
    #1;
    check("c_if_addr", bus_addr, 32'h104);
    check("c_if_rdata", if_rdata, 32'h22223333);
    check("c_if_stallreq", {31'b0, stallreq_if}, 32'd0);
    step();
    bus_ack = 1'b0; if_req = 1'b0;

    // Hold buffer while IF is stalled for three cycles
    step();
    if_req = 1'b1; if_addr = 32'h108;
    step();
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF; stall = 6'b000011;
    #1;
    check("h_ack_rdata", if_rdata, 32'hDEADBEEF);
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    check("h_s1_rdata", if_rdata, 32'hDEADBEEF);
    check("h_s1_stallreq", {31'b0, stallreq_if}, 32'd0);
    check("h_s1_stb", {31'b0, bus_stb}, 32'd0);
    step();
    #1;
    check("h_s2_rdata", if_rdata, 32'hDEADBEEF);
    check("h_s2_stb", {31'b0, bus_stb}, 32'd0);
    stall = 6'b0;
    step();
    if_addr = 32'h10C;
    #1;
    check("h_rel_stallreq", {31'b0, stallreq_if}, 32'd1);
    check("h_rel_stb", {31'b0, bus_stb}, 32'd0);
    step();
    bus_ack = 1'b1; bus_rdata = 32'h55;
    #1;
    check("h_next_addr", bus_addr, 32'h10C);
    step();
    bus_ack = 1'b0; if_req = 1'b0;

    // Flush while a store is outstanding: the store drains to its ack
    step();
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h40; mem_wdata = 32'hCAFEF00D;
    step();
    flush = 1'b1;
    #1;
    check("s_we", {31'b0, bus_we}, 32'd1);
    check("s_sel", {28'b0, bus_sel}, 32'h3);
    check("s_wdata", bus_wdata, 32'hCAFEF00D);
    step();
    flush = 1'b0; mem_req = 1'b0;
    #1;
    check("s_drain_stb", {31'b0, bus_stb}, 32'd1);
    check("s_drain_we", {31'b0, bus_we}, 32'd1);
    check("s_drain_stallreq", {31'b0, stallreq_mem}, 32'd0);
    step();
    step();
    step();
    bus_ack = 1'b1;
    #1;
    check("s_ack_stb", {31'b0, bus_stb}, 32'd1);
    check("s_ack_addr", bus_addr, 32'h40);
    step();
    bus_ack = 1'b0;
    #1;
    check("s_idle_cyc", {31'b0, bus_cyc}, 32'd0);
    check("s_idle_we", {31'b0, bus_we}, 32'd0);

    // Timeout: load never acknowledged, bus_err 8 cycles after strobe rises
    step();
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h3000; bus_rdata = 32'hFFFFFFFF;
    step();
    #1;
    check("t_c0_stb", {31'b0, bus_stb}, 32'd1);
    check("t_c0_err", {31'b0, bus_err}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      #1;
      check($sformatf("t_c%0d_err", i), {31'b0, bus_err}, 32'd0);
      check($sformatf("t_c%0d_stb", i), {31'b0, bus_stb}, 32'd1);
    end
    step();
    #1;
    check("t_err", {31'b0, bus_err}, 32'd1);
    check("t_rdata_zero", mem_rdata, 32'h0);
    check("t_stallreq", {31'b0, stallreq_mem}, 32'd0);
    mem_req = 1'b0;
    step();
    #1;
    check("t_cyc_after", {31'b0, bus_cyc}, 32'd0);
    check("t_err_after", {31'b0, bus_err}, 32'd0);

    // Asynchronous reset in the middle of a DMEM access
    step();
    mem_req = 1'b1; mem_addr = 32'h4000;
    step();
    #1;
    check("r_cyc_before", {31'b0, bus_cyc}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("r_cyc_async", {31'b0, bus_cyc}, 32'd0);
    check("r_stb_async", {31'b0, bus_stb}, 32'd0);
    check("r_addr_async", bus_addr, 32'h0);
    mem_req = 1'b0;
    #3 rst = 1'b1;
    step();
    mem_req = 1'b1; mem_addr = 32'h5000;
    #1;
    check("r_idle_cyc", {31'b0, bus_cyc}, 32'd0);
    step();
    bus_ack = 1'b1; bus_rdata = 32'h600D;
    #1;
    check("r_reissue_addr", bus_addr, 32'h5000);
    check("r_reissue_rdata", mem_rdata, 32'h600D);
    step();
    bus_ack = 1'b0; mem_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
